// File: rtl/tone_divider_pkg.sv
// rtl/tone_divider_pkg.sv - shared FSM state type and mode constants for tone_divider
package tone_divider_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;
endpackage

// File: rtl/tone_div_cnt.sv
// rtl/tone_div_cnt.sv - period counter with compare-based wrap and active/shadow divide registers
module tone_div_cnt #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load_all,
    input  logic             load_shadow,
    input  logic             cnt_en,
    input  logic [WIDTH-1:0] div,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] active_q, active_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;

    assign wrap  = cnt_en && (count_q == active_q);
    assign count = count_q;

    // The wrap takes the shadow value as it stood before this edge, so a
    // coincident shadow load only affects the following period.
    always_comb begin
        count_d  = count_q;
        active_d = active_q;
        shadow_d = shadow_q;
        if (clr) begin
            count_d = '0;
        end else if (load_all) begin
            count_d  = '0;
            active_d = div;
            shadow_d = div;
        end else begin
            if (cnt_en) begin
                if (wrap) begin
                    count_d  = '0;
                    active_d = shadow_q;
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end
            if (load_shadow) begin
                shadow_d = div;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q  <= '0;
            active_q <= '0;
            shadow_q <= '0;
        end else begin
            count_q  <= count_d;
            active_q <= active_d;
            shadow_q <= shadow_d;
        end
    end
endmodule

// File: rtl/tone_divider.sv
// rtl/tone_divider.sv - programmable tone divider FSM with tick and square-wave outputs
// Square-wave flop is built only when TONE_DIVIDER_SQ_EN is defined; otherwise sq is tied low.
module tone_divider
    import tone_divider_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             SCLR,
    input  logic             EN,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] DIV,
    input  logic             MODE,
    output logic [WIDTH-1:0] Cout,
    output logic             c,
    output logic             sq,
    output logic             busy
);
    state_t state_q, state_d;
    logic   c_q, c_d;
    logic   busy_q, busy_d;
    logic   mode_q, mode_d;
    logic   load_all, load_shadow, cnt_en, wrap;

    assign load_all    = !SCLR && LOAD && (state_q != RUN);
    assign load_shadow = !SCLR && LOAD && (state_q == RUN);
    assign cnt_en      = !SCLR && EN && (state_q == RUN);

    tone_div_cnt #(.WIDTH(WIDTH)) u_cnt (
        .clk         (clk),
        .rst         (RST),
        .clr         (SCLR),
        .load_all    (load_all),
        .load_shadow (load_shadow),
        .cnt_en      (cnt_en),
        .div         (DIV),
        .count       (Cout),
        .wrap        (wrap)
    );

    // The end-of-period decision uses the mode latched before this edge.
    always_comb begin
        state_d = state_q;
        c_d     = 1'b0;
        busy_d  = busy_q;
        mode_d  = mode_q;
        if (SCLR) begin
            state_d = IDLE;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (LOAD) begin
                        mode_d = MODE;
                    end
                    if (wrap) begin
                        c_d = 1'b1;
                        if (mode_q == MODE_ONESHOT) begin
                            state_d = DONE;
                            busy_d  = 1'b0;
                        end
                    end
                end
                default: begin
                    if (LOAD) begin
                        mode_d  = MODE;
                        state_d = RUN;
                        busy_d  = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            c_q     <= 1'b0;
            busy_q  <= 1'b0;
            mode_q  <= MODE_PERIODIC;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            busy_q  <= busy_d;
            mode_q  <= mode_d;
        end
    end

    assign c    = c_q;
    assign busy = busy_q;

`ifdef TONE_DIVIDER_SQ_EN
    logic sq_q, sq_d;

    always_comb begin
        sq_d = sq_q;
        if (SCLR) begin
            sq_d = 1'b0;
        end else if (wrap) begin
            sq_d = ~sq_q;
        end
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            sq_q <= 1'b0;
        end else begin
            sq_q <= sq_d;
        end
    end

    assign sq = sq_q;
`else
    assign sq = 1'b0;
`endif
endmodule

// File: tb/tb_tone_divider.sv
// tb/tb_tone_divider.sv - scoreboard bench for tone_divider against a period-level reference model
module tb_tone_divider;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         RST;
    logic         SCLR;
    logic         EN;
    logic         LOAD;
    logic [W-1:0] DIV;
    logic         MODE;
    logic [W-1:0] Cout;
    logic         c;
    logic         sq;
    logic         busy;

    tone_divider #(.WIDTH(W)) dut (
        .clk  (clk),
        .RST  (RST),
        .SCLR (SCLR),
        .EN   (EN),
        .LOAD (LOAD),
        .DIV  (DIV),
        .MODE (MODE),
        .Cout (Cout),
        .c    (c),
        .sq   (sq),
        .busy (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int cout;
        bit c;
        bit sq;
        bit busy;
    } exp_t;

    exp_t sbq[$];

    int sb_checks = 0, sb_pass = 0;
    int dir_checks = 0, dir_pass = 0;
    int dut_ticks = 0;

    // Reference: a tone is "playing" or not; position counts enabled cycles
    // within the current period of length period_len+1.
    bit m_playing, m_oneshot, m_tick, m_tone;
    int m_pos, m_period_len, m_next_len;

    function automatic void model_reset();
        m_playing = 0; m_oneshot = 0; m_tick = 0; m_tone = 0;
        m_pos = 0; m_period_len = 0; m_next_len = 0;
    endfunction

    function automatic void model_edge(bit sclr, bit load, bit en, int div, bit mode);
        bit was_oneshot;
        m_tick = 0;
        if (sclr) begin
            m_playing = 0;
            m_pos = 0;
            m_tone = 0;
        end else if (!m_playing) begin
            if (load) begin
                m_period_len = div;
                m_next_len = div;
                m_oneshot = mode;
                m_playing = 1;
                m_pos = 0;
            end
        end else begin
            was_oneshot = m_oneshot;
            if (en) begin
                if (m_pos == m_period_len) begin
                    m_tick = 1;
                    m_tone = !m_tone;
                    m_pos = 0;
                    m_period_len = m_next_len;
                    if (was_oneshot) m_playing = 0;
                end else begin
                    m_pos = m_pos + 1;
                end
            end
            if (load) begin
                m_next_len = div;
                m_oneshot = mode;
            end
        end
    endfunction

    task automatic push_exp();
        exp_t e;
        e.cyc = cyc + 1;
        e.cout = m_pos;
        e.c = m_tick;
`ifdef TONE_DIVIDER_SQ_EN
        e.sq = m_tone;
`else
        e.sq = 1'b0;
`endif
        e.busy = m_playing;
        sbq.push_back(e);
    endtask

    task automatic step(bit sclr, bit load, bit en, int div, bit mode);
        @(posedge clk);
        #1;
        SCLR = sclr; LOAD = load; EN = en; DIV = W'(div); MODE = mode;
        model_edge(sclr, load, en, div, mode);
        push_exp();
    endtask

    task automatic dir_check(string name, int got, int want);
        dir_checks++;
        if (got == want) dir_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, want);
    endtask

    task automatic check_all_zero(string name);
        dir_check({name, "_cout"}, int'(Cout), 0);
        dir_check({name, "_c"}, int'(c), 0);
        dir_check({name, "_sq"}, int'(sq), 0);
        dir_check({name, "_busy"}, int'(busy), 0);
    endtask

    // Asynchronous reset pulsed between edges, after the last pending item was checked.
    task automatic rst_pulse();
        @(posedge clk);
        @(negedge clk);
        #1;
        SCLR = 0; LOAD = 0; EN = 0; DIV = '0; MODE = 0;
        RST = 1;
        #1;
        check_all_zero("async_rst");
        #1;
        RST = 0;
        model_reset();
        model_edge(0, 0, 0, 0, 0);
        push_exp();
    endtask

    exp_t mon_e;
    always @(negedge clk) begin
        while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
            mon_e = sbq.pop_front();
            sb_checks++;
            if (int'(Cout) == mon_e.cout && c == mon_e.c && sq == mon_e.sq && busy == mon_e.busy)
                sb_pass++;
            else
                $display("FAIL sb cyc=%0d: got Cout=%0d c=%0b sq=%0b busy=%0b, expected Cout=%0d c=%0b sq=%0b busy=%0b",
                         mon_e.cyc, Cout, c, sq, busy, mon_e.cout, mon_e.c, mon_e.sq, mon_e.busy);
        end
        if (c) dut_ticks++;
    end

    int base;

    initial begin
        RST = 1; SCLR = 0; EN = 0; LOAD = 0; DIV = '0; MODE = 0;
        model_reset();
        #1;
        check_all_zero("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        RST = 0;

        // Periodic DIV=5: 30 enabled cycles give 5 ticks.
        step(0, 1, 0, 5, 0);
        base = dut_ticks;
        repeat (30) step(0, 0, 1, 5, 0);
        repeat (2) step(0, 0, 0, 0, 0);
        dir_check("periodic_tick_count", dut_ticks - base, 5);

        // DIV=0: tick every enabled cycle.
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        base = dut_ticks;
        repeat (10) step(0, 0, 1, 0, 0);
        repeat (2) step(0, 0, 0, 0, 0);
        dir_check("div0_tick_count", dut_ticks - base, 10);

        // Shadow update at Cout=3 while running DIV=5.
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 5, 0);
        repeat (3) step(0, 0, 1, 0, 0);
        step(0, 1, 1, 2, 0);
        repeat (12) step(0, 0, 1, 0, 0);

        // One-shot DIV=3, then restart.
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 3, 1);
        base = dut_ticks;
        repeat (25) step(0, 0, 1, 0, 0);
        repeat (2) step(0, 0, 0, 0, 0);
        dir_check("oneshot_tick_count", dut_ticks - base, 1);
        step(0, 1, 0, 3, 1);
        repeat (6) step(0, 0, 1, 0, 0);

        // EN low for 3 cycles at Cout=2.
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 5, 0);
        repeat (2) step(0, 0, 1, 0, 0);
        repeat (3) step(0, 0, 0, 0, 0);
        repeat (10) step(0, 0, 1, 0, 0);

        // Async reset at Cout=4, then SCLR with coincident LOAD.
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 5, 0);
        repeat (4) step(0, 0, 1, 0, 0);
        rst_pulse();
        step(0, 1, 0, 5, 0);
        repeat (2) step(0, 0, 1, 0, 0);
        step(1, 1, 1, 4, 0);
        repeat (4) step(0, 0, 1, 0, 0);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            if (i % 300 == 299) rst_pulse();
            else step(($urandom % 50) == 0, ($urandom % 12) == 0, ($urandom % 5) != 0,
                      int'($urandom % 8), ($urandom % 3) == 0);
        end

        SCLR = 0; LOAD = 0; EN = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        dir_check("scoreboard_drained", sbq.size(), 0);

        $display("%0d/%0d checks passed", sb_pass + dir_pass, sb_checks + dir_checks);
        $finish;
    end
endmodule

// File: doc/tone_divider.md
TONE_DIVIDER -- requirements
Module: tone_divider

Interface
REQ-001 Parameter WIDTH, default 16: width of the divide value and of the counter.
REQ-002 clk  input  1  rising-edge system clock; single clock domain.
REQ-003 RST  input  1  reset, asynchronous, active-high.
REQ-004 SCLR  input  1  synchronous clear, active-high.
REQ-005 EN  input  1  count enable, active-high.
REQ-006 LOAD  input  1  one-cycle strobe; captures DIV and MODE.
REQ-007 DIV  input  WIDTH  terminal count; output period is DIV+1 enabled cycles.
REQ-008 MODE  input  1  0 = periodic, 1 = one-shot; sampled only on LOAD.
REQ-009 Cout  output  WIDTH  current count value.
REQ-010 c  output  1  registered tick pulse, one clk cycle wide.
REQ-011 sq  output  1  square-wave tone output.
REQ-012 busy  output  1  high while the FSM is in RUN.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-014 IDLE: Cout=0, c=0 and busy=0; LOAD SHALL load the active divide and shadow registers from DIV, latch MODE, and enter RUN with Cout=0.
REQ-015 In RUN with EN=1 and Cout==active divide: Cout<=0, c<=1, sq toggles, and active divide<=shadow.
- In periodic mode the FSM stays in RUN.
- In one-shot mode the FSM enters DONE.
REQ-016 In RUN with EN=1 and Cout!=active divide: Cout<=Cout+1 and c<=0.
REQ-017 In RUN with EN=0: Cout and sq hold and c<=0.
REQ-018 LOAD in RUN SHALL update only the shadow register and the latched mode; the new period starts after the current period's wrap.
REQ-019 DONE: Cout=0, c=0, sq holds and busy=0; LOAD SHALL behave exactly as LOAD in IDLE.
REQ-020 DIV=0 SHALL produce c=1 on every enabled cycle; sq then toggles every enabled cycle.
REQ-021 c SHALL be high for exactly the one cycle after the wrapping edge; tick latency is 1 cycle.
REQ-022 LOAD coincident with a wrap in RUN: the wrap SHALL use the old shadow value; the new DIV becomes shadow for the next wrap.
REQ-023 SCLR SHALL have priority over LOAD and EN.
- From any state: next state IDLE, Cout=0, c=0, sq=0.
- The active divide and shadow registers retain their values.
- A simultaneous LOAD is ignored.
REQ-024 The counter never exceeds the active divide; wrap SHALL be by compare, never by overflow.

Reset
REQ-025 RST SHALL, asynchronously and without a clock edge, force the state to IDLE, Cout=0, c=0, sq=0, busy=0, and the active divide, shadow and mode registers to 0.
REQ-026 Deassertion of RST SHALL be synchronised externally; the block samples its inputs from the first clk edge after deassertion.

Configuration
REQ-027 Macro TONE_DIVIDER_SQ_EN:
- Defined: sq SHALL toggle on each wrap, as in REQ-015.
- Undefined: sq SHALL be tied to 0, and no sq flop is synthesised.
- The port exists in both cases.

Structure
REQ-028 Package tone_divider_pkg SHALL hold the state typedef (IDLE/RUN/DONE) and the constants MODE_PERIODIC=0 and MODE_ONESHOT=1.
REQ-029 Sub-module tone_div_cnt SHALL hold the counter, compare and active/shadow divide registers.
REQ-030 The FSM and the c/sq output registers SHALL live in tone_divider.

Verification
REQ-031 Periodic: LOAD DIV=5 MODE=0, then EN=1 for 30 cycles -> c pulses every 6 cycles, Cout runs 0..5, and with the macro defined sq has a 12-cycle period.
REQ-032 DIV=0 MODE=0, EN=1 -> c=1 on every cycle after the first; sq toggles every cycle.
REQ-033 Running DIV=5; LOAD DIV=2 at Cout=3 -> next tick still after Cout=5, then ticks every 3 cycles.
REQ-034 One-shot: LOAD DIV=3 MODE=1 -> single c pulse after 4 enabled cycles, busy drops, no further pulses for 20 cycles; a new LOAD restarts counting.
REQ-035 EN low for 3 cycles at Cout=2 with DIV=5 -> Cout holds at 2 and the tick is delayed by exactly 3 cycles.
REQ-036 RST pulsed between clk edges at Cout=4 -> all outputs 0 before the next edge; SCLR and LOAD in the same cycle -> IDLE, LOAD ignored.
